seven_segments_scan_decoder: RTL
================================

// Module: seven_segments_scan_decoder
// PURPOSE
//  Receive side of the multiplexed seven-segment display bus: watches digit-select (an) and
//  segment (seg, hgfe_dcba) lines, samples each digit once settled, decodes pattern -> hex nibble,
//  assembles a full NUM_DIGITS frame and hands it out on a valid/ready port. Used for display
//  readback/self-check beside the display driver and as a bus monitor in system benches.
// PARAMETERS
//  NUM_DIGITS     8  number of multiplexed digits (an width), 1..8
//  SETTLE_CYCLES  4  consecutive cycles an must be stable one-hot before seg is sampled, >=1
// PORTS
//  clk     in   1             single clock; all logic on posedge clk
//  reset   in   1             synchronous, active-high
//  an      in   NUM_DIGITS    digit select, active-high, one-hot when a digit is driven
//  seg     in   8             segments hgfe_dcba, active-high (bit7 = dp)
//  value   out  4*NUM_DIGITS  decoded frame, digit i in value[4i+3:4i]
//  dp      out  NUM_DIGITS    decimal point of each digit (seg[7] at sample)
//  valid   out  1             frame available; held until ready
//  ready   in   1             consumer accepts frame when valid && ready
//  error   out  1             sticky: undecodable pattern seen; cleared only by reset
//  overrun out  1             sticky: completed frame dropped because valid was pending
// BEHAVIOUR
//  Reset: value=0, dp=0, valid=0, error=0, overrun=0, FSM=S_IDLE, settle count=0, capture mask=0.
//  Reset mid-operation discards any partial frame and pending output.
//  Sampler FSM:
//   S_IDLE   : an not one-hot (zero or multi-hot) -> stay. one-hot -> S_SETTLE, count=1, latch an.
//   S_SETTLE : an == latched -> count++; count==SETTLE_CYCLES -> sample seg, S_HOLD.
//              an changed -> one-hot ? restart S_SETTLE with new an, count=1 : S_IDLE.
//   S_HOLD   : an == latched -> stay (no resample). changed -> as S_SETTLE change rule.
//   Sample happens on the cycle count reaches SETTLE_CYCLES (SETTLE_CYCLES cycles after an edge).
//  Decode: seg[6:0] vs 16-entry table 0..F (0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67
//   A=77 b=7C C=39 d=5E E=79 F=71). No match -> nibble 0, error set next cycle.
//  Frame: sample writes shadow nibble/dp for digit index, sets mask bit. Resampling a digit
//   already in mask overwrites it. Mask all ones -> frame complete, mask cleared same cycle.
//  Output: complete && !valid (or valid&&ready same cycle) -> value/dp <= shadow, valid=1 next cycle.
//   complete && valid && !ready -> frame dropped, overrun=1, output unchanged.
//   valid && ready without complete -> valid=0 next cycle. value/dp stable while valid.
//  Latency: final digit sample -> valid high: 1 cycle.
// CONFIGURATION
//  SEG_BLANK_EN: defined -> seg[6:0]==7'h00 is a legal blank digit: nibble 0, no error, and extra
//   output port blank[NUM_DIGITS] (bit set for blank digits, registered with value).
//   Undefined -> 7'h00 is undecodable (sets error), blank port absent.
// STRUCTURE
//  seven_seg_pkg: typedef logic [7:0] seg_t; typedef enum {S_IDLE,S_SETTLE,S_HOLD} scan_state_t;
//   localparam seg_t SEG_TABLE[16]; SEG_BLANK constant.
//  Sub-module seven_segments_pattern_decode: combinational seg[6:0] -> {hit, nibble[3:0]} (+blank).
//  Top: sampler FSM, settle counter, shadow frame + mask, output register/handshake.
// TESTING
//  1 Reset: hold reset 3 cycles mid-scan -> all outputs 0, FSM S_IDLE, partial frame discarded.
//  2 Clean scan digits 0..7 with patterns for 1,2,3,4,5,6,7,8, each held 6 cycles, ready=1
//    -> value=32'h8765_4321, dp=0, valid 1 cycle after digit-7 sample, error=0.
//  3 Glitch: an one-hot for SETTLE_CYCLES-1 then switches -> no sample, mask unchanged; 2'b11
//    multi-hot -> S_IDLE, no sample.
//  4 Backpressure: ready=0, scan two full frames -> first frame held on value, overrun=1;
//    ready=1 -> valid drops next cycle, value unchanged until third frame.
//  5 Bad pattern seg=8'h49 on digit 3 -> nibble 3 = 0, error=1 and stays 1 after later good frames;
//    seg=8'h80 on digit 0 -> dp[0]=1 and nibble 0 from pattern 7'h00 per SEG_BLANK_EN.
//  6 SEG_BLANK_EN both builds: digit 2 seg=8'h00 -> defined: blank[2]=1, error=0; undefined: error=1.

Source files
------------

// File: rtl/seven_segments_scan_decoder_pkg.sv
// Shared types and constants for the seven-segment scan decoder.
//   seg_t         : one segment byte, hgfe_dcba, bit 7 = decimal point
//   scan_state_t  : sampler FSM states
//   SEG_TABLE     : segment pattern for hex digits 0..F (bit 7 clear)
//   SEG_BLANK     : all-segments-off pattern
//   is_onehot     : true when exactly one bit of an 8-bit vector is set
package seven_segments_scan_decoder_pkg;

    typedef logic [7:0] seg_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD
    } scan_state_t;

    localparam seg_t SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h67, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    localparam seg_t SEG_BLANK = 8'h00;

    function automatic logic is_onehot(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) n++;
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/seven_segments_scan_decoder_if.sv
// Frame output port of the scan decoder: decoded frame plus valid/ready.
//   value [4*NUM_DIGITS] : digit i in value[4i+3:4i]
//   dp    [NUM_DIGITS]   : decimal point of each digit
//   blank [NUM_DIGITS]   : blank-digit flags (only when SEG_BLANK_EN is defined)
//   valid                : frame available, held until accepted
//   ready                : consumer accepts when valid && ready
// master = decoder side, slave = consumer side.
interface seven_segments_scan_decoder_if #(
    parameter int NUM_DIGITS = 8
) ();

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    valid;
    logic                    ready;
`ifdef SEG_BLANK_EN
    logic [NUM_DIGITS-1:0]   blank;

    modport master (output value, output dp, output blank, output valid, input ready);
    modport slave  (input value, input dp, input blank, input valid, output ready);
`else
    modport master (output value, output dp, output valid, input ready);
    modport slave  (input value, input dp, input valid, output ready);
`endif

endinterface

// File: rtl/seven_segments_scan_decoder_pattern_decode.sv
// Combinational segment pattern -> hex nibble lookup.
//   seg    in  7 : segments gfe_dcba (decimal point excluded)
//   hit    out 1 : pattern is decodable
//   nibble out 4 : decoded value, 0 when not decodable
//   blank  out 1 : pattern is all-off (only when SEG_BLANK_EN is defined)
// With SEG_BLANK_EN defined an all-off pattern counts as a legal digit
// (nibble 0); otherwise it is undecodable.
module seven_segments_scan_decoder_pattern_decode
    import seven_segments_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
`ifdef SEG_BLANK_EN
    output logic       blank,
`endif
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_TABLE[i][6:0]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
`ifdef SEG_BLANK_EN
        blank = (seg == SEG_BLANK[6:0]);
        if (blank) hit = 1'b1;
`endif
    end

endmodule

// File: rtl/seven_segments_scan_decoder.sv
// Receive side of a multiplexed seven-segment bus. Waits for the digit
// select to sit stable and one-hot for SETTLE_CYCLES cycles, samples the
// segment lines, decodes the digit and assembles a full frame that is
// handed out on a valid/ready port.
//   clk, reset : single clock, synchronous active-high reset
//   an         : digit select, one-hot when a digit is driven
//   seg        : segments hgfe_dcba, bit 7 = decimal point
//   frame      : frame output port (value, dp, valid, ready, [blank])
//   error      : sticky, an undecodable pattern was sampled
//   overrun    : sticky, a completed frame was dropped under backpressure
// Optional feature macro: SEG_BLANK_EN (all-off digit is legal, adds blank).
module seven_segments_scan_decoder
    import seven_segments_scan_decoder_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_DIGITS-1:0] an,
    input  logic [7:0]            seg,
    seven_segments_scan_decoder_if.master frame,
    output logic                  error,
    output logic                  overrun
);

    localparam int             CW              = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  SETTLE_C        = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0]  ONE_C           = CW'(1);
    // With a one-cycle settle time the first cycle of a new select is
    // already the sampling cycle.
    localparam bit             SAMPLE_ON_ENTRY = (SETTLE_CYCLES == 1);

    scan_state_t             state;
    logic [CW-1:0]           count;
    logic [NUM_DIGITS-1:0]   an_lat;
    logic [NUM_DIGITS-1:0]   mask;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic                    an_oh;
    logic                    an_same;
    logic                    sample;
    logic                    dec_hit;
    logic [3:0]              dec_nibble;
    logic [NUM_DIGITS-1:0]   mask_set;
    logic                    complete;
    logic [4*NUM_DIGITS-1:0] shadow_val_nxt;
    logic [NUM_DIGITS-1:0]   shadow_dp_nxt;

`ifdef SEG_BLANK_EN
    logic                    dec_blank;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   shadow_blank_nxt;
`endif

    seven_segments_scan_decoder_pattern_decode u_decode (
        .seg    (seg[6:0]),
`ifdef SEG_BLANK_EN
        .blank  (dec_blank),
`endif
        .hit    (dec_hit),
        .nibble (dec_nibble)
    );

    assign an_oh   = is_onehot(8'(an));
    assign an_same = (an == an_lat);

    // Sample on the cycle the settle count reaches SETTLE_CYCLES.
    always_comb begin
        sample = 1'b0;
        case (state)
            S_IDLE:   sample = an_oh && SAMPLE_ON_ENTRY;
            S_SETTLE: sample = an_same ? ((count + ONE_C) == SETTLE_C)
                                       : (an_oh && SAMPLE_ON_ENTRY);
            S_HOLD:   sample = !an_same && an_oh && SAMPLE_ON_ENTRY;
            default:  sample = 1'b0;
        endcase
    end

    // The sampled digit is merged into the shadow frame combinationally so a
    // completing frame reaches the output register on the sampling edge.
    always_comb begin
        shadow_val_nxt = shadow_val;
        shadow_dp_nxt  = shadow_dp;
`ifdef SEG_BLANK_EN
        shadow_blank_nxt = shadow_blank;
`endif
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sample && an[i]) begin
                shadow_val_nxt[4*i +: 4] = dec_nibble;
                shadow_dp_nxt[i]         = seg[7];
`ifdef SEG_BLANK_EN
                shadow_blank_nxt[i]      = dec_blank;
`endif
            end
        end
        mask_set = mask | (sample ? an : '0);
        complete = sample && (&mask_set);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            an_lat <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (an_oh) begin
                        an_lat <= an;
                        count  <= ONE_C;
                        state  <= SAMPLE_ON_ENTRY ? S_HOLD : S_SETTLE;
                    end
                end
                S_SETTLE, S_HOLD: begin
                    if (an_same) begin
                        if (state == S_SETTLE) begin
                            count <= count + ONE_C;
                            if ((count + ONE_C) == SETTLE_C) state <= S_HOLD;
                        end
                    end else if (an_oh) begin
                        an_lat <= an;
                        count  <= ONE_C;
                        state  <= SAMPLE_ON_ENTRY ? S_HOLD : S_SETTLE;
                    end else begin
                        count <= '0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    count <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_val  <= '0;
            shadow_dp   <= '0;
            mask        <= '0;
            frame.value <= '0;
            frame.dp    <= '0;
            frame.valid <= 1'b0;
            error       <= 1'b0;
            overrun     <= 1'b0;
`ifdef SEG_BLANK_EN
            shadow_blank <= '0;
            frame.blank  <= '0;
`endif
        end else begin
            shadow_val <= shadow_val_nxt;
            shadow_dp  <= shadow_dp_nxt;
            mask       <= complete ? '0 : mask_set;
`ifdef SEG_BLANK_EN
            shadow_blank <= shadow_blank_nxt;
`endif
            if (sample && !dec_hit) error <= 1'b1;

            if (complete) begin
                if (!frame.valid || frame.ready) begin
                    frame.value <= shadow_val_nxt;
                    frame.dp    <= shadow_dp_nxt;
                    frame.valid <= 1'b1;
`ifdef SEG_BLANK_EN
                    frame.blank <= shadow_blank_nxt;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (frame.valid && frame.ready) begin
                frame.valid <= 1'b0;
            end
        end
    end

endmodule
